// File: rtl/spi_slave_mem.sv
// SPI mode-0 target bridging a command/address/data frame onto a simple
// synchronous byte memory port. Oversamples the SPI pins in the clk_i domain.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame active, waiting for NSS to fall
// CMD     | shifting in the command byte
// ADDR    | shifting in the address byte (read or write command)
// WDATA   | each received byte is written, address post-increments
// RDATA   | MISO driven; read data or ID byte shifted out each byte
// IGNORE  | unknown command, all bits discarded until NSS rises
module spi_slave_mem #(
    parameter int          AW     = 8,
    parameter logic [7:0]  ID_VAL = 8'hA5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          spi_sck_i,
    input  logic          spi_nss_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_wr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_rd_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          busy_o,
    output logic          cmd_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        M_WR,
        M_RD,
        M_ID
    } mode_t;

    // bit 0/1 form the synchroniser, bit 2 is the edge-detect history
    logic [2:0]    sck_pipe_q, sck_pipe_d;
    logic [2:0]    nss_pipe_q, nss_pipe_d;
    logic [1:0]    mosi_pipe_q, mosi_pipe_d;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          mem_wr_q, mem_wr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          rd_load_q, rd_load_d;
    logic          cmd_err_q, cmd_err_d;

    logic          sck_rise, sck_fall;
    logic          nss_rise, nss_fall;
    logic          nss_s;
    logic          mosi_s;
    logic          byte_done;
    logic [7:0]    rx_next;

    // synchroniser shift and edge detection
    always_comb begin
        sck_pipe_d  = {sck_pipe_q[1:0], spi_sck_i};
        nss_pipe_d  = {nss_pipe_q[1:0], spi_nss_i};
        mosi_pipe_d = {mosi_pipe_q[0], spi_mosi_i};
        sck_rise    = sck_pipe_q[1] & ~sck_pipe_q[2];
        sck_fall    = ~sck_pipe_q[1] & sck_pipe_q[2];
        nss_rise    = nss_pipe_q[1] & ~nss_pipe_q[2];
        nss_fall    = ~nss_pipe_q[1] & nss_pipe_q[2];
        nss_s       = nss_pipe_q[1];
        mosi_s      = mosi_pipe_q[1];
        rx_next     = {rx_q[6:0], mosi_s};
        byte_done   = sck_rise && (bit_cnt_q == 3'd7);
    end

    // frame decode: next state, shift registers, address and memory strobes
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_wr_d  = 1'b0;
        mem_rd_d  = 1'b0;
        rd_load_d = mem_rd_q && !nss_rise;
        cmd_err_d = 1'b0;

        // the memory has already sampled addr_q, so bump it now
        if (mem_wr_q) begin
            addr_d = addr_q + 1'b1;
        end
        // read data arrives one cycle after the strobe
        if (rd_load_q && (state_q == S_RDATA)) begin
            tx_d   = mem_rdata_i;
            addr_d = addr_q + 1'b1;
        end

        if (nss_rise) begin
            // end of frame wins over any SCK edge seen in the same cycle
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (nss_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = 3'd0;
                        rx_d      = 8'h00;
                    end
                end
                default: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        rx_d      = rx_next;
                    end
                    // the falling edge right after a byte boundary keeps the freshly loaded MSB
                    if (sck_fall && (bit_cnt_q != 3'd0) && (state_q == S_RDATA)) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        case (state_q)
                            S_CMD: begin
                                case (rx_next)
                                    8'h02: begin
                                        mode_d  = M_WR;
                                        state_d = S_ADDR;
                                    end
                                    8'h03: begin
                                        mode_d  = M_RD;
                                        state_d = S_ADDR;
                                    end
                                    8'h9F: begin
                                        mode_d  = M_ID;
                                        state_d = S_RDATA;
                                        tx_d    = ID_VAL;
                                    end
                                    default: begin
                                        state_d   = S_IGNORE;
                                        cmd_err_d = 1'b1;
                                    end
                                endcase
                            end
                            S_ADDR: begin
                                addr_d = rx_next[AW-1:0];
                                if (mode_q == M_RD) begin
                                    mem_rd_d = 1'b1;
                                    state_d  = S_RDATA;
                                end else begin
                                    state_d  = S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                mem_wr_d = 1'b1;
                                wdata_d  = rx_next;
                            end
                            S_RDATA: begin
                                if (mode_q == M_ID) begin
                                    tx_d = ID_VAL;
                                end else begin
                                    // prefetch the next byte well before the next falling edge
                                    mem_rd_d = 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // state and datapath registers; NSS synchroniser resets to the idle (high) level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_pipe_q  <= 3'b000;
            nss_pipe_q  <= 3'b111;
            mosi_pipe_q <= 2'b00;
            state_q     <= S_IDLE;
            mode_q      <= M_WR;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            sck_pipe_q  <= sck_pipe_d;
            nss_pipe_q  <= nss_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rd_load_q   <= rd_load_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // output drive: MISO only owned in RDATA while the frame is still open
    always_comb begin
        spi_miso_en_o = (state_q == S_RDATA) && !nss_s;
        spi_miso_o    = spi_miso_en_o ? tx_q[7] : 1'b0;
        mem_addr_o    = addr_q;
        mem_wr_o      = mem_wr_q;
        mem_wdata_o   = wdata_q;
        mem_rd_o      = mem_rd_q;
        busy_o        = !nss_s;
        cmd_err_o     = cmd_err_q;
    end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bench for spi_slave_mem: SPI master tasks, a behavioural byte memory,
// and scoreboard queues for expected memory writes and MISO bytes.
module tb_spi_slave_mem;

    localparam int HALF = 50;   // SCK half period, 5 clk_i cycles

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       spi_sck_i;
    logic       spi_nss_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic       spi_miso_en_o;
    logic [7:0] mem_addr_o;
    logic       mem_wr_o;
    logic [7:0] mem_wdata_o;
    logic       mem_rd_o;
    logic [7:0] mem_rdata_i = 8'h00;
    logic       busy_o;
    logic       cmd_err_o;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rx_q [$];

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    spi_slave_mem #(.AW(8), .ID_VAL(8'hA5)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .spi_sck_i     (spi_sck_i),
        .spi_nss_i     (spi_nss_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_en_o (spi_miso_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_o      (mem_wr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rd_o      (mem_rd_o),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o),
        .cmd_err_o     (cmd_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // synchronous memory: write in the strobe cycle, read data one cycle later
    always @(posedge clk_i) begin
        if (mem_wr_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
    end

    // event monitor and write scoreboard
    always @(negedge clk_i) begin
        if (mem_wr_o) begin
            wr_cnt++;
            if (exp_wr_q.size() != 0) check("mem_write", {mem_addr_o, mem_wdata_o}, {16'h0, exp_wr_q.pop_front()});
        end
        if (mem_rd_o) rd_cnt++;
        if (mem_rd_o && mem_wr_o) both_cnt++;
        if (cmd_err_o) err_cnt++;
    end

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] en);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi_i = tx[i];
            #(HALF);
            spi_sck_i = 1'b1;
            rx[i] = spi_miso_o;
            en[i] = spi_miso_en_o;
            #(HALF);
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic spi_bits(input int n, input logic [7:0] tx);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi_i = tx[i];
            #(HALF);
            spi_sck_i = 1'b1;
            #(HALF);
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic frame_begin();
        spi_nss_i = 1'b0;
        #(2*HALF);
    endtask

    task automatic frame_end();
        #(HALF);
        spi_nss_i = 1'b1;
        #(4*HALF);
    endtask

    // send one byte expected to leave MISO released
    task automatic send_quiet(input string tag, input logic [7:0] b);
        logic [7:0] rx, en;
        spi_byte(b, rx, en);
        check(tag, {24'h0, en}, 32'h0);
    endtask

    // clock one data byte and compare against the scoreboard head
    task automatic recv_data(input string tag);
        logic [7:0] rx, en;
        spi_byte(8'h00, rx, en);
        check({tag, "_en"}, {24'h0, en}, 32'hFF);
        if (exp_rx_q.size() != 0) check(tag, {24'h0, rx}, {24'h0, exp_rx_q.pop_front()});
        else check({tag, "_nodata"}, {24'h0, rx}, 32'hFFFF_FFFF);
    endtask

    initial begin
        int w0, r0, e0;
        logic [7:0] rx, en;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n_i    = 1'b0;
        spi_sck_i  = 1'b0;
        spi_nss_i  = 1'b1;
        spi_mosi_i = 1'b0;
        #22;
        check("reset_outs", {spi_miso_o, spi_miso_en_o, mem_addr_o, mem_wr_o, mem_wdata_o,
                             mem_rd_o, busy_o, cmd_err_o}, 32'h0);
        rst_n_i = 1'b1;
        #40;
        check("idle_busy", {31'h0, busy_o}, 32'h0);

        // write burst
        w0 = wr_cnt; r0 = rd_cnt;
        exp_wr_q.push_back({8'h10, 8'hDE});
        exp_wr_q.push_back({8'h11, 8'hAD});
        frame_begin();
        check("busy_frame", {31'h0, busy_o}, 32'h1);
        send_quiet("wr_cmd_en", 8'h02);
        send_quiet("wr_addr_en", 8'h10);
        send_quiet("wr_d0_en", 8'hDE);
        send_quiet("wr_d1_en", 8'hAD);
        frame_end();
        check("wr_count", wr_cnt - w0, 2);
        check("wr_no_read", rd_cnt - r0, 0);

        // read burst
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        exp_rx_q.push_back(8'h5A);
        exp_rx_q.push_back(8'hC3);
        w0 = wr_cnt;
        frame_begin();
        send_quiet("rd_cmd_en", 8'h03);
        send_quiet("rd_addr_en", 8'h20);
        recv_data("rd_d0");
        recv_data("rd_d1");
        frame_end();
        check("rd_en_after", {31'h0, spi_miso_en_o}, 32'h0);
        check("rd_no_write", wr_cnt - w0, 0);

        // read ID
        exp_rx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'hA5);
        frame_begin();
        send_quiet("id_cmd_en", 8'h9F);
        recv_data("id_d0");
        recv_data("id_d1");
        frame_end();

        // address wrap
        w0 = wr_cnt;
        exp_wr_q.push_back({8'hFF, 8'h11});
        exp_wr_q.push_back({8'h00, 8'h22});
        frame_begin();
        send_quiet("wrap_cmd_en", 8'h02);
        send_quiet("wrap_addr_en", 8'hFF);
        send_quiet("wrap_d0_en", 8'h11);
        send_quiet("wrap_d1_en", 8'h22);
        frame_end();
        check("wrap_count", wr_cnt - w0, 2);

        // unknown command
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        frame_begin();
        send_quiet("bad_cmd_en", 8'h55);
        send_quiet("bad_b1_en", 8'hFF);
        frame_end();
        check("bad_err_pulse", err_cnt - e0, 1);
        check("bad_no_strobe", (wr_cnt - w0) + (rd_cnt - r0), 0);

        // abort mid data byte, then a normal frame
        w0 = wr_cnt; e0 = err_cnt;
        frame_begin();
        send_quiet("abort_cmd_en", 8'h02);
        send_quiet("abort_addr_en", 8'h40);
        spi_bits(5, 8'hB7);
        frame_end();
        check("abort_no_write", wr_cnt - w0, 0);
        exp_wr_q.push_back({8'h41, 8'h77});
        frame_begin();
        send_quiet("after_cmd_en", 8'h02);
        send_quiet("after_addr_en", 8'h41);
        send_quiet("after_d0_en", 8'h77);
        frame_end();
        check("after_count", wr_cnt - w0, 1);
        check("after_no_err", err_cnt - e0, 0);

        // reset mid RDATA
        frame_begin();
        send_quiet("rst_cmd_en", 8'h03);
        send_quiet("rst_addr_en", 8'h20);
        spi_bits(3, 8'h00);
        #10;
        check("rst_pre_en", {31'h0, spi_miso_en_o}, 32'h1);
        rst_n_i = 1'b0;
        #10;
        check("rst_mid_outs", {spi_miso_o, spi_miso_en_o, mem_addr_o, mem_wr_o, mem_wdata_o,
                               mem_rd_o, busy_o, cmd_err_o}, 32'h0);
        spi_nss_i = 1'b1;
        #20;
        rst_n_i = 1'b1;
        #40;
        exp_rx_q.push_back(8'hC3);
        frame_begin();
        send_quiet("post_cmd_en", 8'h03);
        send_quiet("post_addr_en", 8'h21);
        recv_data("post_d0");
        frame_end();

        spi_byte(8'hFF, rx, en);
        check("nss_high_ignored", {24'h0, en}, 32'h0);
        #(4*HALF);
        check("exp_wr_left", exp_wr_q.size(), 0);
        check("exp_rx_left", exp_rx_q.size(), 0);
        check("wr_rd_overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
